// File: rtl/digest_reader_if.sv
// Valid/ready stream carrying one working-variable word and its bank address.
interface digest_reader_if #(
  parameter int unsigned WORD_W = 32
) ();
  logic [WORD_W-1:0] out_word;
  logic [3:0]        out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_word,
    output out_addr,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_word,
    input  out_addr,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/digest_reader.sv
// Snapshots working variables A..H on start and streams them out in order with bank addresses 1..8.
module digest_reader #(
  parameter int unsigned WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_W-1:0]    in_A,
  input  logic [WORD_W-1:0]    in_B,
  input  logic [WORD_W-1:0]    in_C,
  input  logic [WORD_W-1:0]    in_D,
  input  logic [WORD_W-1:0]    in_E,
  input  logic [WORD_W-1:0]    in_F,
  input  logic [WORD_W-1:0]    in_G,
  input  logic [WORD_W-1:0]    in_H,
  digest_reader_if.master      bus,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [WORD_W-1:0] snap_q [8];
  logic [WORD_W-1:0] snap_d [8];
  logic [WORD_W-1:0] word_q, word_d;
  logic [3:0]        addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              handshake;

  assign handshake = valid_q & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      word_q  <= '0;
      addr_q  <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      for (int i = 0; i < 8; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    snap_d  = snap_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_d[0] = in_A;
          snap_d[1] = in_B;
          snap_d[2] = in_C;
          snap_d[3] = in_D;
          snap_d[4] = in_E;
          snap_d[5] = in_F;
          snap_d[6] = in_G;
          snap_d[7] = in_H;
          idx_d     = 3'd0;
          word_d    = in_A;
          addr_d    = 4'd1;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = StStream;
        end
      end
      StStream: begin
        if (handshake) begin
          if (idx_q == 3'd7) begin
            word_d  = '0;
            addr_d  = 4'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            state_d = StDone;
          end else begin
            idx_d  = idx_q + 3'd1;
            word_d = snap_q[idx_q + 3'd1];
            // Address is one ahead of the new index: bank encoding starts at A=1.
            addr_d = {1'b0, idx_q} + 4'd2;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.out_word  = word_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_valid = valid_q;
  assign busy          = busy_q;
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_digest_reader.sv
// Directed plus randomized bench for digest_reader, checked against a queue-based reference model.
module tb_digest_reader;

  localparam int unsigned WORD_W = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [WORD_W-1:0] in_w [8];
  logic              busy;
  logic              done;

  digest_reader_if #(.WORD_W(WORD_W)) bus ();

  digest_reader #(.WORD_W(WORD_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in_A  (in_w[0]),
    .in_B  (in_w[1]),
    .in_C  (in_w[2]),
    .in_D  (in_w[3]),
    .in_E  (in_w[4]),
    .in_F  (in_w[5]),
    .in_G  (in_w[6]),
    .in_H  (in_w[7]),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Expected words still owed by the DUT, front is the word that must be on the bus now.
  logic [WORD_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {61'd0, bus.out_valid, busy, done}, 64'd0);
    check({tag, "_out"}, {28'd0, bus.out_addr, bus.out_word}, 64'd0);
  endtask

  task automatic load_words(input logic [WORD_W-1:0] w [8]);
    for (int i = 0; i < 8; i++) in_w[i] = w[i];
  endtask

  task automatic pulse_start();
    exp_q = {};
    for (int i = 0; i < 8; i++) exp_q.push_back(in_w[i]);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ready_mode: 0 always high, 1 pattern 0,1,0,0,1, 2 random.
  task automatic run_stream(input string tag, input int ready_mode, input bit corrupt,
                            input bit restart, input bit abort_at_e);
    int  cyc;
    int  accepted;
    bit  r;
    bit  pattern [5];
    pattern = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cyc = 0;
    accepted = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      check({tag, "_word"}, {32'd0, bus.out_word}, {32'd0, exp_q[0]});
      check({tag, "_addr"}, {60'd0, bus.out_addr}, 64'(9 - exp_q.size()));
      check({tag, "_ctl"}, {61'd0, bus.out_valid, busy, done}, 64'b110);
      if (abort_at_e && accepted == 4) begin
        #2 rst = 1'b1;
        #1;
        check_idle({tag, "_abort"});
        #3 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
          step();
          check_idle({tag, "_postabort"});
        end
        return;
      end
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = pattern[cyc % 5];
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      start = (restart && accepted == 3) ? 1'b1 : 1'b0;
      if (corrupt && cyc == 0) begin
        for (int i = 0; i < 8; i++) in_w[i] = 32'hffff_ffff;
      end
      step();
      start = 1'b0;
      if (r) begin
        void'(exp_q.pop_front());
        accepted++;
      end
      cyc++;
    end
    check({tag, "_bound"}, 64'(exp_q.size()), 64'd0);
    if (ready_mode == 0) check({tag, "_busycycles"}, 64'(cyc), 64'd8);
    check({tag, "_donectl"}, {61'd0, bus.out_valid, busy, done}, 64'b001);
    check({tag, "_doneout"}, {28'd0, bus.out_addr, bus.out_word}, 64'd0);
    start = restart;
    step();
    start = 1'b0;
    check_idle({tag, "_after"});
    step();
    check_idle({tag, "_after2"});
  endtask

  logic [WORD_W-1:0] iv [8];
  logic [WORD_W-1:0] rv [8];

  initial begin
    iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) in_w[i] = '0;
    #3;
    check_idle("reset");
    #9 rst = 1'b0;
    step();
    check_idle("reset_rel");

    // No start: ready high must not produce anything.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_idle("nostart");
    end

    load_words(iv);
    pulse_start();
    run_stream("full", 0, 1'b0, 1'b0, 1'b0);

    load_words(iv);
    pulse_start();
    run_stream("toggle", 1, 1'b0, 1'b0, 1'b0);

    load_words(iv);
    pulse_start();
    run_stream("isolate", 0, 1'b1, 1'b0, 1'b0);

    load_words(iv);
    pulse_start();
    run_stream("restart", 1, 1'b0, 1'b1, 1'b0);

    load_words(iv);
    pulse_start();
    run_stream("abort", 0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) rv[i] = $urandom;
    load_words(rv);
    pulse_start();
    run_stream("fresh", 0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) rv[i] = $urandom;
      load_words(rv);
      pulse_start();
      run_stream("rand", 2, 1'(t % 2), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
